// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls,
// branch/jump flushes, data-memory wait freezes, timeout error and perf counters.
module pipe_hazard_ctrl #(
    parameter logic [1:0] LOAD_WBSEL = 2'b01,
    parameter int          TIMEOUT    = 16,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_regwen,
    input  logic [1:0]       ex_wbsel,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_flush,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int                WCNT_W = $clog2(TIMEOUT + 2);
    localparam logic [WCNT_W-1:0] TO_VAL = WCNT_W'(TIMEOUT);
    localparam logic              TO_EN  = (TIMEOUT != 0);

    typedef enum logic [1:0] {S_RUN, S_WAIT, S_ERR} state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_cnt_q, flush_cnt_q;

    logic mstall;
    logic lu;
    logic stall_inc;
    logic flush_inc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    function automatic logic [WCNT_W-1:0] wait_inc(input logic [WCNT_W-1:0] v);
        return (&v) ? v : v + {{(WCNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign mstall = mem_req & ~mem_ready;
    assign lu     = ex_regwen & (ex_wbsel == LOAD_WBSEL) & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

    assign stall_inc = (mstall | lu) & (state_q != S_ERR);
    assign flush_inc = ex_br_taken & ~mstall & (state_q != S_ERR);

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            S_RUN: begin
                if (mstall) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = {{(WCNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_WAIT: begin
                if (mstall) begin
                    wait_cnt_d = wait_inc(wait_cnt_q);
                    if (TO_EN && (wait_cnt_q == TO_VAL)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end else begin
                    state_d    = S_RUN;
                    wait_cnt_d = '0;
                end
            end
            S_ERR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d    = S_RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Freeze (reset, error, memory wait) outranks branch flush, which outranks load-use.
    always_comb begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        if_id_flush = 1'b0;
        id_ex_en    = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_en   = 1'b0;
        mem_wb_en   = 1'b0;
        if (!rst_n || (state_q == S_ERR) || mstall) begin
            pc_en = 1'b0;
        end else if (ex_br_taken) begin
            pc_en       = 1'b1;
            if_id_en    = 1'b1;
            if_id_flush = 1'b1;
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else if (lu) begin
            id_ex_en    = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_en   = 1'b1;
            mem_wb_en   = 1'b1;
        end else begin
            pc_en     = 1'b1;
            if_id_en  = 1'b1;
            id_ex_en  = 1'b1;
            ex_mem_en = 1'b1;
            mem_wb_en = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (cnt_clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc) stall_cnt_q <= sat_inc(stall_cnt_q);
            if (flush_inc) flush_cnt_q <= sat_inc(flush_cnt_q);
        end
    end

    assign err_o     = err_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=4, CNT_W=4) with hand-computed expectations.
module tb_pipe_hazard_ctrl;

    localparam int CW = 4;

    // Packed control word: {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb}
    localparam logic [6:0] RUN_V = 7'b1101011;
    localparam logic [6:0] LU_V  = 7'b0001111;
    localparam logic [6:0] BR_V  = 7'b1111111;
    localparam logic [6:0] FRZ_V = 7'b0000000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [4:0]    id_rs1, id_rs2, ex_rd;
    logic          id_use_rs1, id_use_rs2, ex_regwen;
    logic [1:0]    ex_wbsel;
    logic          ex_br_taken, mem_req, mem_ready, cnt_clr;
    logic          pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
    logic          err_o;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [6:0]    ctrl;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(
        .LOAD_WBSEL (2'b01),
        .TIMEOUT    (4),
        .CNT_W      (CW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_regwen   (ex_regwen),
        .ex_wbsel    (ex_wbsel),
        .ex_br_taken (ex_br_taken),
        .mem_req     (mem_req),
        .mem_ready   (mem_ready),
        .cnt_clr     (cnt_clr),
        .pc_en       (pc_en),
        .if_id_en    (if_id_en),
        .if_id_flush (if_id_flush),
        .id_ex_en    (id_ex_en),
        .id_ex_flush (id_ex_flush),
        .ex_mem_en   (ex_mem_en),
        .mem_wb_en   (mem_wb_en),
        .err_o       (err_o),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    assign ctrl = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle_inputs();
        id_rs1      = 5'd0;
        id_rs2      = 5'd0;
        id_use_rs1  = 1'b0;
        id_use_rs2  = 1'b0;
        ex_rd       = 5'd0;
        ex_regwen   = 1'b0;
        ex_wbsel    = 2'b00;
        ex_br_taken = 1'b0;
        mem_req     = 1'b0;
        mem_ready   = 1'b0;
        cnt_clr     = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic set_lu(input logic [4:0] r);
        ex_regwen  = 1'b1;
        ex_wbsel   = 2'b01;
        ex_rd      = r;
        id_rs1     = r;
        id_use_rs1 = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        chk("rst_ctrl", 32'(ctrl), 32'(FRZ_V));
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_stall", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush_cnt), 32'd0);
        rst_n = 1'b1;

        // 1: idle pipeline
        for (int i = 0; i < 10; i++) begin
            #1 chk("idle_ctrl", 32'(ctrl), 32'(RUN_V));
            cyc();
        end
        chk("idle_stall", 32'(stall_cnt), 32'd0);
        chk("idle_flush", 32'(flush_cnt), 32'd0);

        // 2: load-use stall, then x0 and gating variants
        do_reset();
        set_lu(5'd5);
        #1 chk("lu_ctrl", 32'(ctrl), 32'(LU_V));
        cyc();
        ex_wbsel = 2'b00;
        #1 chk("lu_gone_ctrl", 32'(ctrl), 32'(RUN_V));
        chk("lu_stall1", 32'(stall_cnt), 32'd1);
        set_lu(5'd0);
        #1 chk("lu_x0_ctrl", 32'(ctrl), 32'(RUN_V));
        cyc();
        chk("lu_x0_stall", 32'(stall_cnt), 32'd1);
        idle_inputs();
        ex_regwen = 1'b1; ex_wbsel = 2'b01; ex_rd = 5'd7;
        id_rs1 = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        #1 chk("lu_rs2_ctrl", 32'(ctrl), 32'(LU_V));
        id_use_rs2 = 1'b0;
        #1 chk("lu_nouse_ctrl", 32'(ctrl), 32'(RUN_V));
        id_use_rs2 = 1'b1; ex_regwen = 1'b0;
        #1 chk("lu_nowen_ctrl", 32'(ctrl), 32'(RUN_V));
        ex_regwen = 1'b1; ex_wbsel = 2'b00;
        #1 chk("lu_notload_ctrl", 32'(ctrl), 32'(RUN_V));

        // 3: branch overrides load-use
        do_reset();
        set_lu(5'd9);
        ex_br_taken = 1'b1;
        #1 chk("br_lu_ctrl", 32'(ctrl), 32'(BR_V));
        cyc();
        idle_inputs();
        #1 chk("br_flush1", 32'(flush_cnt), 32'd1);
        chk("br_after_ctrl", 32'(ctrl), 32'(RUN_V));

        // 4: memory wait holds a pending branch
        do_reset();
        ex_br_taken = 1'b1; mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("mw_frz_ctrl", 32'(ctrl), 32'(FRZ_V));
            cyc();
        end
        mem_ready = 1'b1;
        #1 chk("mw_br_ctrl", 32'(ctrl), 32'(BR_V));
        chk("mw_stall3", 32'(stall_cnt), 32'd3);
        chk("mw_flush0", 32'(flush_cnt), 32'd0);
        cyc();
        idle_inputs();
        #1 chk("mw_flush1", 32'(flush_cnt), 32'd1);
        chk("mw_stall_end", 32'(stall_cnt), 32'd3);
        chk("mw_run_ctrl", 32'(ctrl), 32'(RUN_V));
        chk("mw_err", 32'(err_o), 32'd0);

        // 5: timeout after TIMEOUT+1 stall cycles, sticky until reset
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        repeat (4) cyc();
        chk("to_err_pre", 32'(err_o), 32'd0);
        cyc();
        chk("to_err_set", 32'(err_o), 32'd1);
        chk("to_stall5", 32'(stall_cnt), 32'd5);
        mem_ready = 1'b1; ex_br_taken = 1'b1;
        #1 chk("to_err_ctrl", 32'(ctrl), 32'(FRZ_V));
        cyc();
        chk("to_err_sticky", 32'(err_o), 32'd1);
        chk("to_err_flush", 32'(flush_cnt), 32'd0);
        chk("to_err_stall", 32'(stall_cnt), 32'd5);
        #2 rst_n = 1'b0;
        #1 chk("to_rst_err", 32'(err_o), 32'd0);
        chk("to_rst_ctrl", 32'(ctrl), 32'(FRZ_V));
        chk("to_rst_stall", 32'(stall_cnt), 32'd0);
        idle_inputs();
        cyc();
        rst_n = 1'b1;
        #1 chk("to_run_ctrl", 32'(ctrl), 32'(RUN_V));
        cyc();
        chk("to_run_err", 32'(err_o), 32'd0);
        chk("to_run_stall", 32'(stall_cnt), 32'd0);

        // 6: saturation at 15 and clear priority
        do_reset();
        set_lu(5'd3);
        repeat (20) cyc();
        chk("sat_stall15", 32'(stall_cnt), 32'd15);
        ex_br_taken = 1'b1;
        cnt_clr = 1'b1;
        cyc();
        chk("clr_stall0", 32'(stall_cnt), 32'd0);
        chk("clr_flush0", 32'(flush_cnt), 32'd0);
        cnt_clr = 1'b0;
        cyc();
        chk("post_clr_flush", 32'(flush_cnt), 32'd1);
        chk("post_clr_stall", 32'(stall_cnt), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
